// File: rtl/noc_pe_rx_buffer_if.sv
// Stream bundle between the NoC switch local port, the PE consumer and the rx buffer.
// The slave modport is the buffer's view; master is the environment's view.
interface noc_pe_rx_buffer_if #(
  parameter int TOTAL_WIDTH = 32,
  parameter int DATA_WIDTH  = 24,
  parameter int DEPTH       = 16
);
  localparam int HDR_W = TOTAL_WIDTH - DATA_WIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TOTAL_WIDTH-1:0] i_data;
  logic                   i_valid;
  logic [DATA_WIDTH-1:0]  o_data;
  logic [HDR_W-1:0]       o_hdr;
  logic                   o_valid;
  logic                   i_ready;
  logic [CNT_W-1:0]       o_count;
  logic                   o_almost_full;
  logic                   o_overflow;
  logic                   i_clr_ovf;
  logic [7:0]             o_drop_cnt;
  logic [7:0]             o_misroute_cnt;

  modport slave (
    input  i_data, i_valid, i_ready, i_clr_ovf,
    output o_data, o_hdr, o_valid, o_count, o_almost_full,
           o_overflow, o_drop_cnt, o_misroute_cnt
  );

  modport master (
    output i_data, i_valid, i_ready, i_clr_ovf,
    input  o_data, o_hdr, o_valid, o_count, o_almost_full,
           o_overflow, o_drop_cnt, o_misroute_cnt
  );
endinterface

// File: rtl/noc_pe_rx_buffer.sv
// Receive FWFT FIFO between the NoC switch local output and the PE consumer, with overflow
// accounting. Define PE_RX_ADDR_CHECK_EN to reject and count flits whose header != MY_ADDR.
module noc_pe_rx_buffer #(
  parameter int TOTAL_WIDTH = 32,
  parameter int DATA_WIDTH  = 24,
  parameter int DEPTH       = 16,
  parameter int AF_MARGIN   = 2,
  parameter int MY_ADDR     = 0
) (
  input  logic clk,
  input  logic rst,
  noc_pe_rx_buffer_if.slave bus
);
  localparam int HDR_W = TOTAL_WIDTH - DATA_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

  logic [TOTAL_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wrPtr_q, wrPtr_d;
  logic [AW-1:0]          rdPtr_q, rdPtr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             dropCnt_q, dropCnt_d;
  logic [7:0]             misrouteCnt_q, misrouteCnt_d;

  logic accept, full, push, pop, drop, misroute;

`ifdef PE_RX_ADDR_CHECK_EN
  assign accept = (bus.i_data[TOTAL_WIDTH-1:DATA_WIDTH] == HDR_W'(MY_ADDR));
`else
  logic [HDR_W-1:0] unusedMyAddr;
  assign unusedMyAddr = HDR_W'(MY_ADDR);
  assign accept       = 1'b1;
`endif

  assign full     = (count_q == FULL_CNT);
  assign pop      = (count_q != '0) && bus.i_ready;
  assign push     = bus.i_valid && accept && (!full || pop);
  assign drop     = bus.i_valid && accept && full && !pop;
  assign misroute = bus.i_valid && !accept;

  always_comb begin
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    dropCnt_d     = dropCnt_q;
    misrouteCnt_d = misrouteCnt_q;

    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // A drop racing a clear restarts the count at one but leaves the flag cleared.
    if (bus.i_clr_ovf) begin
      overflow_d = 1'b0;
      dropCnt_d  = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (dropCnt_q != 8'hFF) dropCnt_d = dropCnt_q + 8'd1;
    end

    if (misroute && misrouteCnt_q != 8'hFF) misrouteCnt_d = misrouteCnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      dropCnt_q     <= '0;
      misrouteCnt_q <= '0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      dropCnt_q     <= dropCnt_d;
      misrouteCnt_q <= misrouteCnt_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= bus.i_data;
  end

  assign bus.o_valid        = (count_q != '0);
  assign bus.o_data         = mem_q[rdPtr_q][DATA_WIDTH-1:0];
  assign bus.o_hdr          = mem_q[rdPtr_q][TOTAL_WIDTH-1:DATA_WIDTH];
  assign bus.o_count        = count_q;
  assign bus.o_almost_full  = (count_q >= AF_CNT);
  assign bus.o_overflow     = overflow_q;
  assign bus.o_drop_cnt     = dropCnt_q;
  assign bus.o_misroute_cnt = misrouteCnt_q;
endmodule

// File: tb/tb_noc_pe_rx_buffer.sv
// Directed self-checking bench for noc_pe_rx_buffer (DEPTH=16, AF_MARGIN=2, MY_ADDR=3).
// Expected values are hand-derived; a small queue tracks which payloads should come out.
module tb_noc_pe_rx_buffer;
  localparam int TOTAL_WIDTH = 32;
  localparam int DATA_WIDTH  = 24;
  localparam int DEPTH       = 16;
  localparam int AF_MARGIN   = 2;
  localparam int MY_ADDR     = 3;
`ifdef PE_RX_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;
  int   expQ[$];

  noc_pe_rx_buffer_if #(.TOTAL_WIDTH(TOTAL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

  noc_pe_rx_buffer #(
    .TOTAL_WIDTH(TOTAL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
    .AF_MARGIN(AF_MARGIN), .MY_ADDR(MY_ADDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] hdr, input logic [23:0] payload,
                               input logic ready, input logic clr);
    bus.i_valid   = valid;
    bus.i_data    = {hdr, payload};
    bus.i_ready   = ready;
    bus.i_clr_ovf = clr;
  endtask

  initial begin
    logic [7:0]  singleHdr;
    logic [7:0]  hdrs [4];
    logic [23:0] pays [4];
    int          expCount;

    checkCount = 0;
    failCount  = 0;
    singleHdr  = ADDR_CHK ? 8'h03 : 8'h05;
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    step();
    checkOutput("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("reset_count", {27'd0, bus.o_count}, 32'd0);
    checkOutput("reset_ovf", {31'd0, bus.o_overflow}, 32'd0);
    checkOutput("reset_af", {31'd0, bus.o_almost_full}, 32'd0);
    checkOutput("reset_drop", {24'd0, bus.o_drop_cnt}, 32'd0);
    checkOutput("reset_misroute", {24'd0, bus.o_misroute_cnt}, 32'd0);
    rst = 1'b1;
    step();

    // Single flit in, visible after one edge, gone after the next.
    applyStimulus(1'b1, singleHdr, 24'hABCDEF, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b1, 1'b0);
    checkOutput("single_valid", {31'd0, bus.o_valid}, 32'd1);
    checkOutput("single_hdr", {24'd0, bus.o_hdr}, {24'd0, singleHdr});
    checkOutput("single_data", {8'd0, bus.o_data}, 32'h00ABCDEF);
    step();
    checkOutput("single_empty", {31'd0, bus.o_valid}, 32'd0);

    // Fill with 18 flits while stalled: last two are dropped.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 8'h03, 24'(i), 1'b0, 1'b0);
      step();
      if (i < DEPTH) expQ.push_back(i);
      expCount = (i + 1 > DEPTH) ? DEPTH : i + 1;
      checkOutput($sformatf("fill_count_%0d", i), {27'd0, bus.o_count}, 32'(expCount));
      checkOutput($sformatf("fill_af_%0d", i), {31'd0, bus.o_almost_full}, (expCount >= 14) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
    checkOutput("fill_ovf", {31'd0, bus.o_overflow}, 32'd1);
    checkOutput("fill_drop", {24'd0, bus.o_drop_cnt}, 32'd2);
    checkOutput("fill_head", {8'd0, bus.o_data}, 32'd0);

    // Clear in the same cycle as another drop.
    applyStimulus(1'b1, 8'h03, 24'h000055, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
    checkOutput("clr_race_ovf", {31'd0, bus.o_overflow}, 32'd0);
    checkOutput("clr_race_drop", {24'd0, bus.o_drop_cnt}, 32'd1);
    checkOutput("clr_race_count", {27'd0, bus.o_count}, 32'd16);

    // Full with simultaneous push and pop for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 8'h03, 24'(100 + k), 1'b1, 1'b0);
      checkOutput($sformatf("stream_valid_%0d", k), {31'd0, bus.o_valid}, 32'd1);
      checkOutput($sformatf("stream_data_%0d", k), {8'd0, bus.o_data}, 32'(expQ[0]));
      step();
      void'(expQ.pop_front());
      expQ.push_back(100 + k);
      checkOutput($sformatf("stream_count_%0d", k), {27'd0, bus.o_count}, 32'd16);
    end
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b1, 1'b0);
    checkOutput("stream_drop", {24'd0, bus.o_drop_cnt}, 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput($sformatf("drain_data_%0d", k), {8'd0, bus.o_data}, 32'(expQ[0]));
      step();
      void'(expQ.pop_front());
    end
    checkOutput("drain_empty", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("drain_count", {27'd0, bus.o_count}, 32'd0);

    // Hold 7 entries, then pulse reset between edges.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 8'h03, 24'(200 + k), 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_count", {27'd0, bus.o_count}, 32'd7);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("async_count", {27'd0, bus.o_count}, 32'd0);
    checkOutput("async_drop", {24'd0, bus.o_drop_cnt}, 32'd0);
    #2 rst = 1'b1;
    step();
    applyStimulus(1'b1, 8'h03, 24'h000777, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b1, 1'b0);
    checkOutput("post_reset_count", {27'd0, bus.o_count}, 32'd1);
    checkOutput("post_reset_data", {8'd0, bus.o_data}, 32'h777);
    step();
    checkOutput("post_reset_alone", {31'd0, bus.o_valid}, 32'd0);

    // Address filtering: headers 3, 4, 3, 9.
    hdrs[0] = 8'h03; pays[0] = 24'h000031;
    hdrs[1] = 8'h04; pays[1] = 24'h000041;
    hdrs[2] = 8'h03; pays[2] = 24'h000032;
    hdrs[3] = 8'h09; pays[3] = 24'h000091;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, hdrs[k], pays[k], 1'b0, 1'b0);
      step();
      if (!ADDR_CHK || hdrs[k] == 8'(MY_ADDR)) expQ.push_back(int'(pays[k]));
    end
    applyStimulus(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
    checkOutput("addr_count", {27'd0, bus.o_count}, ADDR_CHK ? 32'd2 : 32'd4);
    checkOutput("addr_misroute", {24'd0, bus.o_misroute_cnt}, ADDR_CHK ? 32'd2 : 32'd0);
    checkOutput("addr_drop", {24'd0, bus.o_drop_cnt}, 32'd0);
    bus.i_ready = 1'b1;
    while (expQ.size() > 0) begin
      checkOutput("addr_data", {8'd0, bus.o_data}, 32'(expQ[0]));
      step();
      void'(expQ.pop_front());
    end
    checkOutput("addr_empty", {31'd0, bus.o_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
